iot_riscv_wb_stage: RTL and testbench

- Writeback stage of the iot_riscv pipeline, directly upstream of the register file.
- Accepts retiring EX-stage results (ALU results and loads), waits for data-memory load responses, and aligns and sign-extends load data.
- Drives the register-file write port (rd_*) and the ID-stage forwarding signals (fwd_*).
- Raises a load-use stall towards ID while a load to a register ID is reading is still outstanding.

---
 rtl/iot_riscv_wb_stage.sv | 176 +++++++++++++++++
 tb/tb_iot_riscv_wb_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iot_riscv_wb_stage.sv
// ============================================================================
// Module   : iot_riscv_wb_stage
// Brief    : Writeback stage: retires ALU results, waits for load responses,
//            aligns/sign-extends load data, drives regfile write + forwarding.
//            Optional load watchdog under `IOT_RISCV_WB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iot_riscv_wb_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        main_clk_i,
    input  logic        main_rst_i,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        ex_rd_we_i,
    input  logic [4:0]  ex_rd_index_i,
    input  logic [31:0] ex_result_i,
    input  logic        ex_load_i,
    input  logic [1:0]  ex_load_size_i,
    input  logic        ex_load_unsigned_i,
    input  logic [1:0]  ex_addr_lsb_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_err_i,
    input  logic [4:0]  id_ra_index_i,
    input  logic [4:0]  id_rb_index_i,
    output logic [4:0]  rd_index_o,
    output logic [31:0] rd_value_o,
    output logic        rd_we_o,
    output logic [31:0] fwd_data_o,
    output logic        fwd_a_en_o,
    output logic        fwd_b_en_o,
    output logic        load_stall_o,
    output logic        lsu_fault_o
);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } state_t;

    state_t      r_state;
    logic [4:0]  r_pend_idx;
    logic        r_pend_we;
    logic [1:0]  r_pend_size;
    logic        r_pend_uns;
    logic [1:0]  r_pend_lsb;
    logic [4:0]  r_rd_index;
    logic [31:0] r_rd_value;
    logic        r_rd_we;
    logic        r_fault;

    logic        w_xfer;
    logic        w_misaligned;
    logic        w_load_start;
    logic        w_tmo_expired;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_value;

    assign w_xfer       = ex_valid_i & (r_state == ST_IDLE);
    assign w_misaligned = ((ex_load_size_i == 2'd1) & ex_addr_lsb_i[0])
                        | ((ex_load_size_i == 2'd2) & (ex_addr_lsb_i != 2'd0))
                        |  (ex_load_size_i == 2'd3);
    assign w_load_start = w_xfer & ex_load_i & ~w_misaligned;

    always_comb begin
        w_byte = dmem_rdata_i[7:0];
        case (r_pend_lsb)
            2'd1:    w_byte = dmem_rdata_i[15:8];
            2'd2:    w_byte = dmem_rdata_i[23:16];
            2'd3:    w_byte = dmem_rdata_i[31:24];
            default: w_byte = dmem_rdata_i[7:0];
        endcase
        w_half = r_pend_lsb[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (r_pend_size)
            2'd0:    w_load_value = {{24{~r_pend_uns & w_byte[7]}}, w_byte};
            2'd1:    w_load_value = {{16{~r_pend_uns & w_half[15]}}, w_half};
            default: w_load_value = dmem_rdata_i;
        endcase
    end

`ifdef IOT_RISCV_WB_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;

    // Expiry is flagged in the cycle the count would reach the limit, so the
    // fault appears TIMEOUT_CYCLES cycles after entering WAIT_LOAD.
    assign w_tmo_expired = (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge main_clk_i or posedge main_rst_i) begin
        if (main_rst_i) begin
            r_tmo_cnt <= 16'd0;
        end else if (w_load_start) begin
            r_tmo_cnt <= 16'd0;
        end else if ((r_state == ST_WAIT_LOAD) && !dmem_rvalid_i) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_tmo_expired    = 1'b0;
    assign w_unused_timeout = ^16'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge main_clk_i or posedge main_rst_i) begin
        if (main_rst_i) begin
            r_state     <= ST_IDLE;
            r_pend_idx  <= 5'd0;
            r_pend_we   <= 1'b0;
            r_pend_size <= 2'd0;
            r_pend_uns  <= 1'b0;
            r_pend_lsb  <= 2'd0;
            r_rd_index  <= 5'd0;
            r_rd_value  <= 32'd0;
            r_rd_we     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_rd_we <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        if (!ex_load_i) begin
                            r_rd_we    <= ex_rd_we_i & (ex_rd_index_i != 5'd0);
                            r_rd_index <= ex_rd_index_i;
                            r_rd_value <= ex_result_i;
                        end else if (w_misaligned) begin
                            r_fault <= 1'b1;
                        end else begin
                            r_pend_idx  <= ex_rd_index_i;
                            r_pend_we   <= ex_rd_we_i;
                            r_pend_size <= ex_load_size_i;
                            r_pend_uns  <= ex_load_unsigned_i;
                            r_pend_lsb  <= ex_addr_lsb_i;
                            r_state     <= ST_WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT_LOAD: begin
                    // A response arriving together with watchdog expiry wins.
                    if (dmem_rvalid_i) begin
                        r_state <= ST_IDLE;
                        if (dmem_err_i) begin
                            r_fault <= 1'b1;
                        end else begin
                            r_rd_we    <= r_pend_we & (r_pend_idx != 5'd0);
                            r_rd_index <= r_pend_idx;
                            r_rd_value <= w_load_value;
                        end
                    end else if (w_tmo_expired) begin
                        r_state <= ST_IDLE;
                        r_fault <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ex_ready_o   = (r_state == ST_IDLE);
    assign rd_index_o   = r_rd_index;
    assign rd_value_o   = r_rd_value;
    assign rd_we_o      = r_rd_we;
    assign lsu_fault_o  = r_fault;
    assign fwd_data_o   = r_rd_value;
    assign fwd_a_en_o   = r_rd_we & (r_rd_index == id_ra_index_i);
    assign fwd_b_en_o   = r_rd_we & (r_rd_index == id_rb_index_i);
    assign load_stall_o = (r_state == ST_WAIT_LOAD) & r_pend_we & (r_pend_idx != 5'd0)
                        & ((r_pend_idx == id_ra_index_i) | (r_pend_idx == id_rb_index_i));

endmodule

`default_nettype wire

// File: tb/tb_iot_riscv_wb_stage.sv
// ============================================================================
// Module   : tb_iot_riscv_wb_stage
// Brief    : Self-checking bench for iot_riscv_wb_stage (vector table, directed
//            load sequences and randomized traffic against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iot_riscv_wb_stage;

    logic        main_clk_i = 1'b0;
    logic        main_rst_i;
    logic        ex_valid_i, ex_ready_o, ex_rd_we_i, ex_load_i, ex_load_unsigned_i;
    logic [4:0]  ex_rd_index_i, id_ra_index_i, id_rb_index_i, rd_index_o;
    logic [31:0] ex_result_i, dmem_rdata_i, rd_value_o, fwd_data_o;
    logic [1:0]  ex_load_size_i, ex_addr_lsb_i;
    logic        dmem_rvalid_i, dmem_err_i;
    logic        rd_we_o, fwd_a_en_o, fwd_b_en_o, load_stall_o, lsu_fault_o;

    int checks = 0;
    int errors = 0;

    iot_riscv_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
        .main_clk_i(main_clk_i), .main_rst_i(main_rst_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_rd_we_i(ex_rd_we_i), .ex_rd_index_i(ex_rd_index_i),
        .ex_result_i(ex_result_i), .ex_load_i(ex_load_i),
        .ex_load_size_i(ex_load_size_i), .ex_load_unsigned_i(ex_load_unsigned_i),
        .ex_addr_lsb_i(ex_addr_lsb_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .dmem_err_i(dmem_err_i),
        .id_ra_index_i(id_ra_index_i), .id_rb_index_i(id_rb_index_i),
        .rd_index_o(rd_index_o), .rd_value_o(rd_value_o), .rd_we_o(rd_we_o),
        .fwd_data_o(fwd_data_o), .fwd_a_en_o(fwd_a_en_o), .fwd_b_en_o(fwd_b_en_o),
        .load_stall_o(load_stall_o), .lsu_fault_o(lsu_fault_o)
    );

    always #5 main_clk_i = ~main_clk_i;

    typedef struct {
        logic        we;
        logic [4:0]  idx;
        logic [31:0] res;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        exp_we;
        logic        exp_fa;
        logic        exp_fb;
    } alu_vec_t;

    alu_vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge main_clk_i);
        #2;
    endtask

    task automatic do_load(input logic we, input logic [4:0] idx, input logic [1:0] size,
                           input logic uns, input logic [1:0] lsb);
        ex_valid_i = 1'b1; ex_load_i = 1'b1; ex_rd_we_i = we; ex_rd_index_i = idx;
        ex_load_size_i = size; ex_load_unsigned_i = uns; ex_addr_lsb_i = lsb;
        tick();
        ex_valid_i = 1'b0; ex_load_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = data; dmem_err_i = err;
        tick();
        dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0;
    endtask

    // Reference load value: select the addressed lane arithmetically, then extend.
    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] size,
                                             input logic uns, input logic [1:0] lsb);
        longint v;
        int     bits;
        if (size == 2'd0) begin
            bits = 8;
            v = longint'(rdata >> (int'(lsb) * 8)) % 256;
        end else if (size == 2'd1) begin
            bits = 16;
            v = longint'(rdata >> ((int'(lsb) / 2) * 16)) % 65536;
        end else begin
            return rdata;
        end
        if (!uns && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'h0000_1234, 5'd5,  5'd0,  1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 5'd9,  32'hAAAA_5555, 5'd9,  5'd9,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd1,  5'd31, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 5'd12, 32'h0000_0000, 5'd12, 5'd12, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 5'd1,  32'h8000_0000, 5'd2,  5'd3,  1'b1, 1'b0, 1'b0};

        main_rst_i = 1'b1;
        ex_valid_i = 0; ex_rd_we_i = 0; ex_rd_index_i = 0; ex_result_i = 0; ex_load_i = 0;
        ex_load_size_i = 0; ex_load_unsigned_i = 0; ex_addr_lsb_i = 0;
        dmem_rvalid_i = 0; dmem_rdata_i = 0; dmem_err_i = 0;
        id_ra_index_i = 0; id_rb_index_i = 0;
        tick(); tick();
        chk("reset_rd_we", 32'(rd_we_o), 32'd0);
        chk("reset_rd_index", 32'(rd_index_o), 32'd0);
        chk("reset_rd_value", rd_value_o, 32'd0);
        chk("reset_fault", 32'(lsu_fault_o), 32'd0);
        chk("reset_stall", 32'(load_stall_o), 32'd0);
        chk("reset_fwd", 32'({fwd_a_en_o, fwd_b_en_o}), 32'd0);
        chk("reset_ready", 32'(ex_ready_o), 32'd1);
        main_rst_i = 1'b0;
        tick();

        // Back-to-back ALU retirements, one per cycle.
        for (int i = 0; i < 6; i++) begin
            ex_valid_i = 1'b1; ex_load_i = 1'b0; ex_rd_we_i = vecs[i].we;
            ex_rd_index_i = vecs[i].idx; ex_result_i = vecs[i].res;
            id_ra_index_i = vecs[i].ra; id_rb_index_i = vecs[i].rb;
            tick();
            chk($sformatf("vec%0d_rd_we", i), 32'(rd_we_o), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_rd_index", i), 32'(rd_index_o), 32'(vecs[i].idx));
            chk($sformatf("vec%0d_rd_value", i), rd_value_o, vecs[i].res);
            chk($sformatf("vec%0d_fwd_data", i), fwd_data_o, vecs[i].res);
            chk($sformatf("vec%0d_fwd_a", i), 32'(fwd_a_en_o), 32'(vecs[i].exp_fa));
            chk($sformatf("vec%0d_fwd_b", i), 32'(fwd_b_en_o), 32'(vecs[i].exp_fb));
        end
        ex_valid_i = 1'b0;
        tick();

        // LB / LBU rd=7, lsb=2, response 3 cycles after entry.
        for (int u = 0; u < 2; u++) begin
            id_ra_index_i = 5'd0; id_rb_index_i = 5'd7;
            do_load(1'b1, 5'd7, 2'd0, 1'(u), 2'd2);
            chk("lb_stall", 32'(load_stall_o), 32'd1);
            chk("lb_ready_wait", 32'(ex_ready_o), 32'd0);
            tick(); tick();
            chk("lb_still_waiting", 32'(load_stall_o), 32'd1);
            respond(32'h1280_3456, 1'b0);
            chk("lb_rd_we", 32'(rd_we_o), 32'd1);
            chk("lb_rd_index", 32'(rd_index_o), 32'd7);
            chk("lb_rd_value", rd_value_o, (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            chk("lb_ready_after", 32'(ex_ready_o), 32'd1);
            chk("lb_stall_after", 32'(load_stall_o), 32'd0);
        end

        // Misaligned LH, then LHU upper half.
        do_load(1'b1, 5'd4, 2'd1, 1'b0, 2'd1);
        chk("lh_mis_fault", 32'(lsu_fault_o), 32'd1);
        chk("lh_mis_we", 32'(rd_we_o), 32'd0);
        chk("lh_mis_ready", 32'(ex_ready_o), 32'd1);
        tick();
        chk("lh_mis_fault_pulse", 32'(lsu_fault_o), 32'd0);
        do_load(1'b1, 5'd4, 2'd1, 1'b1, 2'd2);
        respond(32'h8001_0000, 1'b0);
        chk("lhu_value", rd_value_o, 32'h0000_8001);
        chk("lhu_we", 32'(rd_we_o), 32'd1);

        // LW with bus error.
        do_load(1'b1, 5'd3, 2'd2, 1'b0, 2'd0);
        respond(32'hCAFE_F00D, 1'b1);
        chk("lw_err_fault", 32'(lsu_fault_o), 32'd1);
        chk("lw_err_we", 32'(rd_we_o), 32'd0);
        chk("lw_err_ready", 32'(ex_ready_o), 32'd1);

        // Reset mid-load, late response ignored.
        id_ra_index_i = 5'd9;
        do_load(1'b1, 5'd9, 2'd2, 1'b0, 2'd0);
        tick();
        main_rst_i = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(ex_ready_o), 32'd1);
        chk("rst_mid_stall", 32'(load_stall_o), 32'd0);
        main_rst_i = 1'b0;
        respond(32'h0000_0055, 1'b0);
        chk("late_rvalid_we", 32'(rd_we_o), 32'd0);
        chk("late_rvalid_value", rd_value_o, 32'd0);

`ifdef IOT_RISCV_WB_TIMEOUT_EN
        do_load(1'b1, 5'd4, 2'd2, 1'b0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("tmo_no_fault_yet", 32'(lsu_fault_o), 32'd0);
        end
        tick();
        chk("tmo_fault", 32'(lsu_fault_o), 32'd1);
        chk("tmo_we", 32'(rd_we_o), 32'd0);
        chk("tmo_ready", 32'(ex_ready_o), 32'd1);
`endif

        // Randomized traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic        is_load, we, uns, misal, exp_we, err;
            logic [4:0]  idx;
            logic [1:0]  size, lsb;
            logic [31:0] res, rdata;
            int          dly;
            is_load = ($urandom_range(0, 2) != 0);
            we  = ($urandom_range(0, 3) != 0);
            idx = 5'($urandom);
            res = $urandom;
            size = 2'($urandom); lsb = 2'($urandom); uns = 1'($urandom);
            id_ra_index_i = ($urandom_range(0, 1) != 0) ? idx : 5'($urandom);
            id_rb_index_i = 5'($urandom);
            exp_we = we && (idx != 5'd0);
            if (!is_load) begin
                ex_valid_i = 1'b1; ex_load_i = 1'b0; ex_rd_we_i = we;
                ex_rd_index_i = idx; ex_result_i = res;
                tick();
                ex_valid_i = 1'b0;
                chk("rnd_alu_we", 32'(rd_we_o), 32'(exp_we));
                if (exp_we) chk("rnd_alu_value", rd_value_o, res);
                chk("rnd_alu_fwd_a", 32'(fwd_a_en_o), 32'(exp_we && idx == id_ra_index_i));
                chk("rnd_alu_fault", 32'(lsu_fault_o), 32'd0);
            end else begin
                misal = (size == 2'd3) || (size == 2'd1 && (lsb % 2) == 1)
                     || (size == 2'd2 && lsb != 2'd0);
                do_load(we, idx, size, uns, lsb);
                if (misal) begin
                    chk("rnd_mis_fault", 32'(lsu_fault_o), 32'd1);
                    chk("rnd_mis_we", 32'(rd_we_o), 32'd0);
                end else begin
                    chk("rnd_ld_ready", 32'(ex_ready_o), 32'd0);
                    chk("rnd_ld_stall", 32'(load_stall_o),
                        32'(exp_we && (idx == id_ra_index_i || idx == id_rb_index_i)));
                    dly = $urandom_range(0, 3);
                    for (int d = 0; d < dly; d++) tick();
                    err = ($urandom_range(0, 9) == 0);
                    rdata = $urandom;
                    respond(rdata, err);
                    if (err) begin
                        chk("rnd_err_fault", 32'(lsu_fault_o), 32'd1);
                        chk("rnd_err_we", 32'(rd_we_o), 32'd0);
                    end else begin
                        chk("rnd_ld_we", 32'(rd_we_o), 32'(exp_we));
                        if (exp_we) chk("rnd_ld_value", rd_value_o, ref_load(rdata, size, uns, lsb));
                    end
                    chk("rnd_ld_ready_after", 32'(ex_ready_o), 32'd1);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
